// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM state type and coin value constants for the vending controller.
package vend_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, REFUND} state_e;
  localparam int COIN5_UNITS  = 1;
  localparam int COIN10_UNITS = 2;
  function automatic logic [1:0] coin_units(input logic c5, input logic c10);
    return (c5 ? 2'(COIN5_UNITS) : 2'd0) + (c10 ? 2'(COIN10_UNITS) : 2'd0);
  endfunction
endpackage

// File: rtl/vend_refund_ctr.sv
// vend_refund_ctr: loadable down-counter, one registered change pulse per count, done at zero.
module vend_refund_ctr #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] val_i,
  output logic          change_o,
  output logic          done_o,
  output logic [CW-1:0] cnt_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q;
  assign cnt_d = load_i ? val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= cnt_d != '0;
    end
  end
  assign change_o = pulse_q;
  assign done_o   = cnt_q == '0;
  assign cnt_o    = cnt_q;
endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-operated vending controller; define VEND_CANCEL_EN to make the cancel input refund credit.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE_UNITS = 3,
  parameter int CW          = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          coin_5,
  input  logic          coin_10,
  input  logic          cancel,
  output logic          dispensed,
  output logic          change,
  output logic          coin_reject,
  output logic          busy,
  output logic [CW-1:0] credit
);
  localparam logic [CW-1:0] PRICE = CW'(PRICE_UNITS);
  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d, sum, rem, load_val, rcnt;
  logic          disp_d, rej_d, load, cxl, coin, done;
  assign coin = coin_5 | coin_10;
  assign sum  = credit_q + CW'(coin_units(coin_5, coin_10));
  assign rem  = credit_q - PRICE;
  assign busy = state_q == DISPENSE || state_q == REFUND;
`ifdef VEND_CANCEL_EN
  assign cxl = cancel && state_q == COLLECT;
`else
  assign cxl = 1'b0 & cancel;
`endif
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    disp_d   = 1'b0;
    rej_d    = coin && busy;
    load     = 1'b0;
    load_val = rem;
    case (state_q)
      IDLE, COLLECT: begin
        if (cxl) begin
          load     = 1'b1;
          load_val = credit_q;
          credit_d = '0;
          rej_d    = coin;
          state_d  = REFUND;
        end else begin
          credit_d = sum;
          disp_d   = sum >= PRICE;
          state_d  = sum >= PRICE ? DISPENSE : (sum != '0 ? COLLECT : IDLE);
        end
      end
      DISPENSE: begin
        credit_d = '0;
        load     = rem != '0;
        state_d  = rem != '0 ? REFUND : IDLE;
      end
      REFUND:   state_d = (done || rcnt == CW'(1)) ? IDLE : REFUND;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      dispensed   <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      dispensed   <= disp_d;
      coin_reject <= rej_d;
    end
  end
  // While refunding, the counter owns the outstanding credit
  vend_refund_ctr #(.CW(CW)) u_refund (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .val_i   (load_val),
    .change_o(change),
    .done_o  (done),
    .cnt_o   (rcnt)
  );
  assign credit = state_q == REFUND ? rcnt : credit_q;
endmodule
